ebpc_enc_scheduler: RTL and testbench

- Shares one ebpc_encoder instance between N_IN input streams, such as feature-map channels from different producers.
- Grants whole packets in round-robin order: once granted, a stream keeps the encoder until its last beat.
- Records the granted source in an ID FIFO and tags each packet on the encoder's ZNZ and BPC output streams with its source ID.
- The two output streams complete independently, so the FIFO has one read pointer per stream. Sits directly upstream of ebpc_encoder.

---
 rtl/ebpc_pkg.sv | 11 +
 rtl/ebpc_id_fifo.sv | 93 +++++++++
 rtl/ebpc_enc_scheduler.sv | 136 +++++++++++++
 tb/tb_ebpc_enc_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebpc_pkg.sv
// Shared types and constants for the EBPC encoder front end.
package ebpc_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [0:0] {
        SCHED_IDLE,
        SCHED_STREAM
    } sched_state_t;

endpackage

// File: rtl/ebpc_id_fifo.sv
// Source-ID FIFO with one write port and independent ZNZ/BPC read pointers.
// An entry is freed only after both output streams have popped it.
module ebpc_id_fifo
    import ebpc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            znz_pop,
    input  logic            bpc_pop,
    output logic            full,
    output logic [ID_W-1:0] znz_id,
    output logic            znz_vld,
    output logic [ID_W-1:0] bpc_id,
    output logic            bpc_vld
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] znz_rp;
    logic [PTR_W-1:0] bpc_rp;
    logic [CNT_W-1:0] znz_cnt;
    logic [CNT_W-1:0] bpc_cnt;
    logic             push_ok;
    logic             znz_pop_ok;
    logic             bpc_pop_ok;

    assign full       = (znz_cnt == CNT_W'(DEPTH)) || (bpc_cnt == CNT_W'(DEPTH));
    assign push_ok    = push && !full;
    assign znz_pop_ok = znz_pop && (znz_cnt != '0);
    assign bpc_pop_ok = bpc_pop && (bpc_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp <= '0;
        end else if (push_ok) begin
            mem[wp] <= push_id;
            wp      <= wp + PTR_W'(1);
        end
    end

    // Simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            znz_rp  <= '0;
            znz_cnt <= '0;
        end else begin
            if (znz_pop_ok) begin
                znz_rp <= znz_rp + PTR_W'(1);
            end
            if (push_ok && !znz_pop_ok) begin
                znz_cnt <= znz_cnt + CNT_W'(1);
            end else if (!push_ok && znz_pop_ok) begin
                znz_cnt <= znz_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bpc_rp  <= '0;
            bpc_cnt <= '0;
        end else begin
            if (bpc_pop_ok) begin
                bpc_rp <= bpc_rp + PTR_W'(1);
            end
            if (push_ok && !bpc_pop_ok) begin
                bpc_cnt <= bpc_cnt + CNT_W'(1);
            end else if (!push_ok && bpc_pop_ok) begin
                bpc_cnt <= bpc_cnt - CNT_W'(1);
            end
        end
    end

    assign znz_id  = mem[znz_rp];
    assign znz_vld = (znz_cnt != '0);
    assign bpc_id  = mem[bpc_rp];
    assign bpc_vld = (bpc_cnt != '0);

    znz_pop_nonempty: assert property (@(posedge clk) disable iff (rst) !(znz_pop && znz_cnt == '0));
    bpc_pop_nonempty: assert property (@(posedge clk) disable iff (rst) !(bpc_pop && bpc_cnt == '0));

endmodule

// File: rtl/ebpc_enc_scheduler.sv
// Round-robin packet scheduler sharing one ebpc_encoder between N_IN streams,
// tagging each packet on the ZNZ and BPC outputs with its source ID.
module ebpc_enc_scheduler
    import ebpc_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int ID_FIFO_DEPTH = 4,
    parameter int ID_W          = $clog2(N_IN)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [N_IN*DATA_W-1:0] in_data_i,
    input  logic [N_IN-1:0]        in_last_i,
    input  logic [N_IN-1:0]        in_vld_i,
    output logic [N_IN-1:0]        in_rdy_o,
    output logic [DATA_W-1:0]      enc_data_o,
    output logic                   enc_last_o,
    output logic                   enc_vld_o,
    input  logic                   enc_rdy_i,
    input  logic                   enc_idle_i,
    input  logic                   znz_vld_i,
    input  logic                   znz_rdy_i,
    input  logic                   znz_last_i,
    input  logic                   bpc_vld_i,
    input  logic                   bpc_rdy_i,
    input  logic                   bpc_last_i,
    output logic [ID_W-1:0]        znz_id_o,
    output logic                   znz_id_vld_o,
    output logic [ID_W-1:0]        bpc_id_o,
    output logic                   bpc_id_vld_o,
    output logic                   idle_o
);

    sched_state_t    state;
    sched_state_t    state_nxt;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] grant_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_nxt;
    logic [ID_W-1:0] winner;
    int              idx;
    logic            fifo_full;
    logic            grant;
    logic            beat_last;
    logic            znz_pop;
    logic            bpc_pop;

    // First valid stream at or after rr_ptr; scanning backwards lets the
    // closest candidate overwrite the farther ones.
    always_comb begin
        winner = rr_ptr;
        idx    = 0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (in_vld_i[ID_W'(idx)]) begin
                winner = ID_W'(idx);
            end
        end
    end

    assign grant     = (state == SCHED_IDLE) && en_i && (|in_vld_i) && !fifo_full;
    assign beat_last = (state == SCHED_STREAM) && in_vld_i[grant_q] && enc_rdy_i
                       && in_last_i[grant_q];
    assign znz_pop   = znz_vld_i && znz_rdy_i && znz_last_i;
    assign bpc_pop   = bpc_vld_i && bpc_rdy_i && bpc_last_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= SCHED_IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            rr_ptr  <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        rr_nxt    = rr_ptr;
        case (state)
            SCHED_IDLE: begin
                if (grant) begin
                    grant_nxt = winner;
                    state_nxt = SCHED_STREAM;
                end
            end
            SCHED_STREAM: begin
                if (beat_last) begin
                    rr_nxt    = (grant_q == ID_W'(N_IN - 1)) ? '0 : grant_q + ID_W'(1);
                    state_nxt = SCHED_IDLE;
                end
            end
            default: state_nxt = SCHED_IDLE;
        endcase
    end

    always_comb begin
        in_rdy_o   = '0;
        enc_data_o = '0;
        enc_last_o = 1'b0;
        enc_vld_o  = 1'b0;
        if (state == SCHED_STREAM) begin
            enc_data_o        = in_data_i[grant_q*DATA_W +: DATA_W];
            enc_last_o        = in_last_i[grant_q];
            enc_vld_o         = in_vld_i[grant_q];
            in_rdy_o[grant_q] = enc_rdy_i;
        end
    end

    ebpc_id_fifo #(
        .DEPTH (ID_FIFO_DEPTH),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (grant),
        .push_id (winner),
        .znz_pop (znz_pop),
        .bpc_pop (bpc_pop),
        .full    (fifo_full),
        .znz_id  (znz_id_o),
        .znz_vld (znz_id_vld_o),
        .bpc_id  (bpc_id_o),
        .bpc_vld (bpc_id_vld_o)
    );

    assign idle_o = (state == SCHED_IDLE) && !znz_id_vld_o && !bpc_id_vld_o && enc_idle_i;

endmodule

// File: tb/tb_ebpc_enc_scheduler.sv
// Directed bench for ebpc_enc_scheduler; encoder and its output streams are
// modelled by driving the handshake inputs directly.
module tb_ebpc_enc_scheduler;
    import ebpc_pkg::*;

    localparam int N_IN = 4;
    localparam int ID_W = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [DATA_W-1:0]      d [N_IN];
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN-1:0]        in_last;
    logic [N_IN-1:0]        in_vld;
    logic [N_IN-1:0]        in_rdy;
    logic [DATA_W-1:0]      enc_data;
    logic                   enc_last;
    logic                   enc_vld;
    logic                   enc_rdy;
    logic                   enc_idle;
    logic                   znz_vld, znz_rdy, znz_last;
    logic                   bpc_vld, bpc_rdy, bpc_last;
    logic [ID_W-1:0]        znz_id;
    logic                   znz_id_vld;
    logic [ID_W-1:0]        bpc_id;
    logic                   bpc_id_vld;
    logic                   idle;

    int total = 0;
    int bad   = 0;

    assign in_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    ebpc_enc_scheduler #(
        .N_IN          (N_IN),
        .ID_FIFO_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .in_vld_i     (in_vld),
        .in_rdy_o     (in_rdy),
        .enc_data_o   (enc_data),
        .enc_last_o   (enc_last),
        .enc_vld_o    (enc_vld),
        .enc_rdy_i    (enc_rdy),
        .enc_idle_i   (enc_idle),
        .znz_vld_i    (znz_vld),
        .znz_rdy_i    (znz_rdy),
        .znz_last_i   (znz_last),
        .bpc_vld_i    (bpc_vld),
        .bpc_rdy_i    (bpc_rdy),
        .bpc_last_i   (bpc_last),
        .znz_id_o     (znz_id),
        .znz_id_vld_o (znz_id_vld),
        .bpc_id_o     (bpc_id),
        .bpc_id_vld_o (bpc_id_vld),
        .idle_o       (idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_in();
        en       = 1'b1;
        in_vld   = '0;
        in_last  = '0;
        for (int k = 0; k < N_IN; k++) d[k] = '0;
        enc_rdy  = 1'b1;
        enc_idle = 1'b1;
        znz_vld  = 1'b0; znz_rdy = 1'b0; znz_last = 1'b0;
        bpc_vld  = 1'b0; bpc_rdy = 1'b0; bpc_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        tick();
        rst = 1'b0;
    endtask

    task automatic snoop(input logic z, input logic b);
        znz_vld = z; znz_rdy = z; znz_last = z;
        bpc_vld = b; bpc_rdy = b; bpc_last = b;
    endtask

    int               exp_rdy [14];
    int               beat [N_IN];
    int               g;
    logic [N_IN-1:0]  rdy_s;

    initial begin
        // reset values
        rst = 1'b1;
        clr_in();
        settle();
        chk("rst in_rdy",     32'(in_rdy), 0);
        chk("rst enc_vld",    32'(enc_vld), 0);
        chk("rst enc_data",   32'(enc_data), 0);
        chk("rst enc_last",   32'(enc_last), 0);
        chk("rst znz_id_vld", 32'(znz_id_vld), 0);
        chk("rst bpc_id_vld", 32'(bpc_id_vld), 0);
        chk("rst znz_id",     32'(znz_id), 0);
        chk("rst bpc_id",     32'(bpc_id), 0);
        chk("rst idle",       32'(idle), 1);
        tick();
        rst = 1'b0;

        // single stream 2: 5,0,7
        in_vld[2] = 1'b1; d[2] = 8'd5;
        settle();
        chk("s1 idle rdy", 32'(in_rdy), 0);
        chk("s1 idle vld", 32'(enc_vld), 0);
        tick();
        chk("s1 vld",     32'(enc_vld), 1);
        chk("s1 data0",   32'(enc_data), 5);
        chk("s1 rdy",     32'(in_rdy), 4);
        chk("s1 znz_vld", 32'(znz_id_vld), 1);
        chk("s1 znz_id",  32'(znz_id), 2);
        chk("s1 bpc_id",  32'(bpc_id), 2);
        tick();
        d[2] = 8'd0;
        settle();
        chk("s1 data1", 32'(enc_data), 0);
        chk("s1 last1", 32'(enc_last), 0);
        tick();
        d[2] = 8'd7; in_last[2] = 1'b1;
        settle();
        chk("s1 data2", 32'(enc_data), 7);
        chk("s1 last2", 32'(enc_last), 1);
        tick();
        in_vld = '0; in_last = '0;
        settle();
        chk("s1 post vld",  32'(enc_vld), 0);
        chk("s1 busy idle", 32'(idle), 0);
        chk("s1 znz hold",  32'(znz_id_vld), 1);
        snoop(1'b1, 1'b0);
        tick();
        snoop(1'b0, 1'b0);
        settle();
        chk("s1 znz done",  32'(znz_id_vld), 0);
        chk("s1 bpc still", 32'(bpc_id_vld), 1);
        chk("s1 bpc id",    32'(bpc_id), 2);
        snoop(1'b0, 1'b1);
        tick();
        snoop(1'b0, 1'b0);
        settle();
        chk("s1 bpc done", 32'(bpc_id_vld), 0);
        chk("s1 idle",     32'(idle), 1);

        // round robin, all streams valid, 2-beat packets
        do_reset();
        exp_rdy = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1};
        for (int k = 0; k < N_IN; k++) begin
            beat[k] = 0;
            d[k]    = 8'(k * 16);
        end
        in_vld = '1;
        for (int c = 0; c < 14; c++) begin
            snoop((c % 3 == 0) && (c > 0), (c % 3 == 0) && (c > 0));
            settle();
            rdy_s = in_rdy;
            chk("rr rdy", 32'(in_rdy), exp_rdy[c]);
            if (exp_rdy[c] != 0) begin
                g = 0;
                for (int k = 0; k < N_IN; k++) if (exp_rdy[c] == (1 << k)) g = k;
                chk("rr data", 32'(enc_data), g * 16 + beat[g]);
                chk("rr last", 32'(enc_last), beat[g]);
            end
            tick();
            for (int k = 0; k < N_IN; k++) begin
                if (rdy_s[k]) beat[k] = 1 - beat[k];
                in_last[k] = (beat[k] == 1);
                d[k]       = 8'(k * 16 + beat[k]);
            end
        end
        snoop(1'b0, 1'b0);

        // FIFO full with ZNZ stalled
        do_reset();
        in_vld = 4'b0001; in_last = 4'b0001; d[0] = 8'd9;
        repeat (8) tick();
        settle();
        chk("full rdy",     32'(in_rdy), 0);
        chk("full enc_vld", 32'(enc_vld), 0);
        chk("full znz vld", 32'(znz_id_vld), 1);
        snoop(1'b0, 1'b1);
        tick();
        snoop(1'b0, 1'b0);
        settle();
        chk("full znz blocks", 32'(in_rdy), 0);
        tick();
        snoop(1'b1, 1'b0);
        settle();
        chk("full pop cycle", 32'(in_rdy), 0);
        tick();
        snoop(1'b0, 1'b0);
        settle();
        chk("full grant cycle", 32'(in_rdy), 0);
        tick();
        chk("full regrant", 32'(in_rdy), 1);

        // unequal drain: ids 1,3 then BPC runs ahead
        do_reset();
        in_vld = 4'b1010; in_last = 4'b1010; d[1] = 8'd1; d[3] = 8'd3;
        repeat (4) tick();
        in_vld = '0;
        settle();
        chk("ud znz id0", 32'(znz_id), 1);
        chk("ud bpc id0", 32'(bpc_id), 1);
        snoop(1'b0, 1'b1);
        tick();
        snoop(1'b0, 1'b0);
        settle();
        chk("ud bpc id1", 32'(bpc_id), 3);
        chk("ud znz id1", 32'(znz_id), 1);
        snoop(1'b0, 1'b1);
        tick();
        snoop(1'b0, 1'b0);
        settle();
        chk("ud bpc empty", 32'(bpc_id_vld), 0);
        chk("ud znz id2",   32'(znz_id), 1);
        chk("ud znz vld",   32'(znz_id_vld), 1);
        in_vld = 4'b0001; in_last = 4'b0001;
        repeat (4) tick();
        chk("ud blocked a", 32'(in_rdy), 0);
        tick();
        chk("ud blocked b", 32'(in_rdy), 0);
        chk("ud bpc vld",   32'(bpc_id_vld), 1);
        chk("ud bpc id3",   32'(bpc_id), 0);
        in_vld = '0;

        // en_i dropped mid-packet
        do_reset();
        in_vld = 4'b0011; in_last = 4'b0010; d[0] = 8'h0A; d[1] = 8'h11;
        tick();
        en = 1'b0;
        settle();
        chk("en mid rdy", 32'(in_rdy), 1);
        repeat (3) tick();
        in_last[0] = 1'b1;
        settle();
        chk("en last",     32'(enc_last), 1);
        chk("en last rdy", 32'(in_rdy), 1);
        tick();
        chk("en hold a", 32'(in_rdy), 0);
        tick();
        chk("en hold b", 32'(in_rdy), 0);
        chk("en hold vld", 32'(enc_vld), 0);
        en = 1'b1;
        tick();
        chk("en resume rdy",  32'(in_rdy), 2);
        chk("en resume data", 32'(enc_data), 8'h11);
        tick();
        in_vld = '0; in_last = '0;

        // reset in the middle of a stream-2 packet
        in_vld = 4'b0100; d[2] = 8'h20;
        repeat (3) tick();
        settle();
        chk("mr streaming", 32'(in_rdy), 4);
        rst = 1'b1;
        settle();
        chk("mr rdy",      32'(in_rdy), 0);
        chk("mr enc_vld",  32'(enc_vld), 0);
        chk("mr enc_data", 32'(enc_data), 0);
        chk("mr znz_vld",  32'(znz_id_vld), 0);
        chk("mr bpc_vld",  32'(bpc_id_vld), 0);
        chk("mr idle",     32'(idle), 1);
        in_vld = 4'b0101; d[0] = 8'h33;
        tick();
        rst = 1'b0;
        tick();
        chk("mr regrant rdy",  32'(in_rdy), 1);
        chk("mr regrant data", 32'(enc_data), 8'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
